alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter W, default 8, datapath width in bits (W >= 4).
REQ-002 The block SHALL have parameter MUL_EN, default 1, enabling the multi-cycle multiply on opcode 4'b0001.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning opcode and operands are presented.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts an operation this cycle.
REQ-007 The block SHALL have port opcode, input, 4, operation select.
REQ-008 The block SHALL have ports operand_A and operand_B, each input, W, the operands.
REQ-009 The block SHALL have port out_valid, output, 1, a one-cycle pulse marking result/flag update.
REQ-010 The block SHALL have port result, output, W, the registered result (multiply low half).
REQ-011 The block SHALL have port result_hi, output, W, the registered multiply high half (0 for other ops).
REQ-012 The block SHALL have port flag, output, 3, with [0]=N (sign), [1]=Z (zero), [2]=C (carry); all registered.

Function
REQ-013 An operation SHALL be accepted when in_valid && in_ready on a rising edge.
REQ-014 Single-cycle ops: result, flags and out_valid SHALL update on the accepting edge, so latency is 1.
REQ-015 Pass (0000, 0010, 0011, and 0001 when MUL_EN=0): result=A; flags unchanged.
REQ-016 Add (0100, 1100): result=(A+B) mod 2^W; C=carry out of bit W-1; N and Z unchanged.
REQ-017 Subtract (0101, 1101):
- A<B (unsigned): result=B-A, N=1.
- Otherwise: result=A-B, N=0.
- C and Z unchanged in both cases.
REQ-018 Compare (0111, 1111): result unchanged.
- A<B: C=1, Z=0.
- A==B: C=0, Z=1.
- A>B: C=0, Z=0.
- N unchanged.
REQ-019 Logic ops SHALL leave flags unchanged:
- AND (0110, 1110): result=A&B.
- OR (1000, 1001): result=A|B.
- XOR (1010, 1011): result=A^B.
REQ-020 Multiply (0001, MUL_EN=1) SHALL behave as follows:
- Unsigned shift-add, one partial-product step per cycle.
- FSM: IDLE -> MUL_RUN on acceptance; stays in MUL_RUN for exactly W cycles; then IDLE.
- {result_hi,result}=A*B; out_valid pulses on the edge leaving MUL_RUN, so latency is W+1 edges from acceptance.
- Z=1 if the 2W-bit product is 0, else Z=0; C=1 if result_hi!=0, else C=0; N unchanged.
REQ-021 in_ready SHALL be 1 in IDLE and 0 in MUL_RUN; in_valid during MUL_RUN SHALL be ignored, with no state change.
REQ-022 result_hi SHALL be cleared to 0 by every accepted non-multiply op that writes result.
REQ-023 out_valid SHALL be 0 in every cycle without a completing operation, including idle cycles with in_valid=0.
REQ-024 Operand values SHALL be latched at acceptance; later operand changes SHALL not affect an in-flight multiply.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL apply these values on that edge:
- result=0, result_hi=0, flag=3'b000, out_valid=0.
- FSM=IDLE; multiplier counter and accumulators=0.
REQ-026 Reset asserted during MUL_RUN SHALL abort the multiply with no out_valid pulse; in_ready=1 on the next cycle.
REQ-027 Reset SHALL take priority over a simultaneous in_valid; that operation is dropped.

Structure
REQ-028 Package alu_pkg SHALL hold:
- Opcode localparams.
- FSM state typedef (IDLE, MUL_RUN).
- Flag index constants FLAG_N=0, FLAG_Z=1, FLAG_C=2.
REQ-029 The iterative multiplier SHALL be sub-module alu_mul_iter, parameterised by W, with start/done handshake, clk and rst.
REQ-030 All opcode decoding SHALL use alu_pkg constants; no literal opcodes in alu_pipe.

Verification (W=8)
REQ-031 After reset, ADD A=8'hF0, B=8'h20 -> next edge result=8'h10, C=1, out_valid=1 for one cycle.
REQ-032 SUB A=3, B=5 -> result=2, N=1; then SUB A=5, B=3 -> result=2, N=0; C/Z retained from prior ops.
REQ-033 CMP A=7, B=7 -> Z=1, C=0, result unchanged; CMP A=1, B=2 -> Z=0, C=1.
REQ-034 MUL A=8'hFF, B=8'hFF:
- in_ready=0 for 8 cycles; a second in_valid during that window is ignored.
- At edge 9: result=8'h01, result_hi=8'hFE, C=1, Z=0.
REQ-035 MUL A=0, B=8'h55 -> product 0, Z=1, C=0; separately, rst mid-multiply -> no out_valid, all outputs 0.
REQ-036 Back-to-back single-cycle ops with in_valid held high -> one out_valid per cycle; AND 8'hCC, 8'hAA = 8'h88.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the ALU pipeline.
package alu_pkg;

   localparam logic [3:0] OP_PASS0 = 4'b0000;
   localparam logic [3:0] OP_MUL   = 4'b0001;
   localparam logic [3:0] OP_PASS2 = 4'b0010;
   localparam logic [3:0] OP_PASS3 = 4'b0011;
   localparam logic [3:0] OP_ADD0  = 4'b0100;
   localparam logic [3:0] OP_ADD1  = 4'b1100;
   localparam logic [3:0] OP_SUB0  = 4'b0101;
   localparam logic [3:0] OP_SUB1  = 4'b1101;
   localparam logic [3:0] OP_AND0  = 4'b0110;
   localparam logic [3:0] OP_AND1  = 4'b1110;
   localparam logic [3:0] OP_CMP0  = 4'b0111;
   localparam logic [3:0] OP_CMP1  = 4'b1111;
   localparam logic [3:0] OP_OR0   = 4'b1000;
   localparam logic [3:0] OP_OR1   = 4'b1001;
   localparam logic [3:0] OP_XOR0  = 4'b1010;
   localparam logic [3:0] OP_XOR1  = 4'b1011;

   localparam int FLAG_N = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 2;

   typedef enum logic {IDLE, MUL_RUN} state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one partial product per cycle; done asserts during the W-th step.
// Operands are captured on start; prod_nxt carries the full product in the done cycle.
module alu_mul_iter #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           done,
   output logic [2*W-1:0] prod_nxt
);

   localparam int CW = $clog2(W);

   logic           busy;
   logic [CW-1:0]  cnt;
   logic [2*W-1:0] mcand;
   logic [W-1:0]   mplier;
   logic [2*W-1:0] prod;

   assign prod_nxt = mplier[0] ? prod + mcand : prod;
   assign done     = busy && (cnt == CW'(W-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= '0;
         mcand  <= {{W{1'b0}}, a};
         mplier <= b;
         prod   <= '0;
      end else if (busy) begin
         prod   <= prod_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU: single-cycle ops complete on the accepting edge, multiply takes W+1 edges.
// in_ready drops while a multiply runs; in_valid in that window is ignored.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int W      = 8,
   parameter int MUL_EN = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   opcode,
   input  logic [W-1:0] operand_A,
   input  logic [W-1:0] operand_B,
   output logic         out_valid,
   output logic [W-1:0] result,
   output logic [W-1:0] result_hi,
   output logic [2:0]   flag
);

   state_t         state;
   logic           accept;
   logic           mul_start;
   logic           mul_done;
   logic [2*W-1:0] mul_prod;
   logic [W:0]     sum;
   logic           a_lt_b;

   assign in_ready  = (state == IDLE);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && !rst && (MUL_EN != 0) && (opcode == OP_MUL);
   assign sum       = {1'b0, operand_A} + {1'b0, operand_B};
   assign a_lt_b    = operand_A < operand_B;

   alu_mul_iter #(.W(W)) u_mul (
      .clk      (clk),
      .rst      (rst),
      .start    (mul_start),
      .a        (operand_A),
      .b        (operand_B),
      .done     (mul_done),
      .prod_nxt (mul_prod)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         result    <= '0;
         result_hi <= '0;
         flag      <= 3'b000;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  out_valid <= 1'b1;
                  case (opcode)
                     OP_MUL: begin
                        if (MUL_EN != 0) begin
                           state     <= MUL_RUN;
                           out_valid <= 1'b0;
                        end else begin
                           result    <= operand_A;
                           result_hi <= '0;
                        end
                     end
                     OP_ADD0, OP_ADD1: begin
                        result       <= sum[W-1:0];
                        result_hi    <= '0;
                        flag[FLAG_C] <= sum[W];
                     end
                     OP_SUB0, OP_SUB1: begin
                        // Magnitude of the difference; N records which way round it went
                        result       <= a_lt_b ? operand_B - operand_A : operand_A - operand_B;
                        result_hi    <= '0;
                        flag[FLAG_N] <= a_lt_b;
                     end
                     OP_CMP0, OP_CMP1: begin
                        flag[FLAG_C] <= a_lt_b;
                        flag[FLAG_Z] <= (operand_A == operand_B);
                     end
                     OP_AND0, OP_AND1: begin
                        result    <= operand_A & operand_B;
                        result_hi <= '0;
                     end
                     OP_OR0, OP_OR1: begin
                        result    <= operand_A | operand_B;
                        result_hi <= '0;
                     end
                     OP_XOR0, OP_XOR1: begin
                        result    <= operand_A ^ operand_B;
                        result_hi <= '0;
                     end
                     default: begin
                        result    <= operand_A;
                        result_hi <= '0;
                     end
                  endcase
               end
            end
            MUL_RUN: begin
               if (mul_done) begin
                  state        <= IDLE;
                  out_valid    <= 1'b1;
                  result       <= mul_prod[W-1:0];
                  result_hi    <= mul_prod[2*W-1:W];
                  flag[FLAG_Z] <= (mul_prod == '0);
                  flag[FLAG_C] <= (mul_prod[2*W-1:W] != '0);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at W=8 with hand-computed expectations.
module tb_alu_pipe;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   opcode;
   logic [W-1:0] operand_A;
   logic [W-1:0] operand_B;
   logic         out_valid;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic [2:0]   flag;

   int n_checks = 0;
   int n_errors = 0;
   int pulses;

   always #5 clk = ~clk;

   alu_pipe #(.W(W), .MUL_EN(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .operand_A (operand_A),
      .operand_B (operand_B),
      .out_valid (out_valid),
      .result    (result),
      .result_hi (result_hi),
      .flag      (flag)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [7:0] res, input logic [7:0] hi,
                             input logic [2:0] flg, input logic ov);
      check_val({tag, ".result"}, 32'(result), 32'(res));
      check_val({tag, ".result_hi"}, 32'(result_hi), 32'(hi));
      check_val({tag, ".flag"}, 32'(flag), 32'(flg));
      check_val({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      in_valid  = v;
      opcode    = op;
      operand_A = a;
      operand_B = b;
   endtask

   initial begin
      // Reset with an ADD presented: the op must be dropped
      rst = 1'b1;
      drive(1'b1, 4'b0100, 8'hF0, 8'h20);
      tick;
      tick;
      check_outs("reset", 8'h00, 8'h00, 3'b000, 1'b0);
      check_val("reset.in_ready", 32'(in_ready), 32'd1);

      rst = 1'b0;
      drive(1'b1, 4'b0100, 8'hF0, 8'h20);
      tick;
      check_outs("add_carry", 8'h10, 8'h00, 3'b100, 1'b1);
      drive(1'b0, 4'b0100, 8'h01, 8'h01);
      tick;
      check_outs("idle", 8'h10, 8'h00, 3'b100, 1'b0);

      drive(1'b1, 4'b0101, 8'd3, 8'd5);
      tick;
      check_outs("sub_lt", 8'd2, 8'h00, 3'b101, 1'b1);
      drive(1'b1, 4'b1101, 8'd5, 8'd3);
      tick;
      check_outs("sub_ge", 8'd2, 8'h00, 3'b100, 1'b1);

      drive(1'b1, 4'b0111, 8'd7, 8'd7);
      tick;
      check_outs("cmp_eq", 8'd2, 8'h00, 3'b010, 1'b1);
      drive(1'b1, 4'b1111, 8'd1, 8'd2);
      tick;
      check_outs("cmp_lt", 8'd2, 8'h00, 3'b100, 1'b1);

      // Multiply with later in_valid/operand churn that must be ignored
      drive(1'b1, 4'b0001, 8'hFF, 8'hFF);
      tick;
      check_val("mul_ff.busy0.in_ready", 32'(in_ready), 32'd0);
      check_val("mul_ff.busy0.out_valid", 32'(out_valid), 32'd0);
      for (int i = 1; i < 8; i++) begin
         drive(1'b1, 4'b0100, 8'(i), 8'h11);
         tick;
         check_val($sformatf("mul_ff.busy%0d.in_ready", i), 32'(in_ready), 32'd0);
         check_val($sformatf("mul_ff.busy%0d.out_valid", i), 32'(out_valid), 32'd0);
      end
      drive(1'b1, 4'b0100, 8'h09, 8'h09);
      tick;
      check_outs("mul_ff", 8'h01, 8'hFE, 3'b100, 1'b1);
      check_val("mul_ff.in_ready", 32'(in_ready), 32'd1);

      drive(1'b1, 4'b0100, 8'd1, 8'd1);
      tick;
      check_outs("add_clr_hi", 8'd2, 8'h00, 3'b000, 1'b1);
      drive(1'b1, 4'b0101, 8'd1, 8'd2);
      tick;
      check_outs("sub_n", 8'd1, 8'h00, 3'b001, 1'b1);

      drive(1'b1, 4'b0001, 8'h00, 8'h55);
      tick;
      drive(1'b0, 4'b0001, 8'hAA, 8'hAA);
      pulses = 0;
      repeat (7) begin
         tick;
         if (out_valid) pulses++;
      end
      check_val("mul_zero.early_pulses", 32'(pulses), 32'd0);
      tick;
      check_outs("mul_zero", 8'h00, 8'h00, 3'b011, 1'b1);

      // Back-to-back single-cycle ops with in_valid held high
      drive(1'b1, 4'b0110, 8'hCC, 8'hAA);
      tick;
      check_outs("and", 8'h88, 8'h00, 3'b011, 1'b1);
      drive(1'b1, 4'b1000, 8'h0F, 8'hF0);
      tick;
      check_outs("or", 8'hFF, 8'h00, 3'b011, 1'b1);
      drive(1'b1, 4'b1011, 8'hFF, 8'h0F);
      tick;
      check_outs("xor", 8'hF0, 8'h00, 3'b011, 1'b1);
      drive(1'b1, 4'b0010, 8'h5A, 8'h33);
      tick;
      check_outs("pass", 8'h5A, 8'h00, 3'b011, 1'b1);
      drive(1'b1, 4'b1100, 8'h80, 8'h80);
      tick;
      check_outs("add_wrap", 8'h00, 8'h00, 3'b111, 1'b1);

      // Reset in the middle of a multiply
      drive(1'b1, 4'b0001, 8'd3, 8'd4);
      tick;
      drive(1'b0, 4'b0000, 8'h00, 8'h00);
      repeat (3) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check_outs("rst_mul", 8'h00, 8'h00, 3'b000, 1'b0);
      check_val("rst_mul.in_ready", 32'(in_ready), 32'd1);
      pulses = 0;
      repeat (W + 2) begin
         tick;
         if (out_valid) pulses++;
      end
      check_val("rst_mul.late_pulses", 32'(pulses), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
